// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths:
// FSM state encodings, frame geometry, line idle level and the parity rule.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  // Even parity: the parity bit is the XOR of the data bits, so data plus
  // parity always carries an even number of ones. The RX checker uses the
  // same function, which keeps both ends of the link in agreement.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte-source side of the UART transmitter: request/data inputs plus the
// serial line and status outputs. The byte source drives through 'master',
// the transmitter sits on 'slave'.
interface uart_tx_frame_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] TX_DATA;
  logic                 data_valid;
  logic                 parity_enable;
  logic                 TX_OUT;
  logic                 busy;
  logic                 tx_done;

  modport master (
    output TX_DATA, data_valid, parity_enable,
    input  TX_OUT, busy, tx_done
  );

  modport slave (
    input  TX_DATA, data_valid, parity_enable,
    output TX_OUT, busy, tx_done
  );

endinterface

// File: rtl/uart_tx_frame_parity.sv
// Even parity generator for one data byte; mirror image of the RX-side
// parity checker, built on the same shared XOR-reduction rule.
module parity_generator
  import uart_pkg::*;
(
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 parity_o
);

  assign parity_o = even_parity(data_i);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: accepts one byte per handshake while idle and sends
// start bit, 8 data bits LSB-first, optional even parity bit and one stop bit,
// each held for CLKS_PER_BIT clocks. All outputs come straight from flops.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  tx_if
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tx_out_q, tx_out_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 gen_parity;

  parity_generator u_parity (
    .data_i   (tx_if.TX_DATA),
    .parity_o (gen_parity)
  );

  // Next-state logic: frame sequencing, baud counter, bit index and latches.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + CW'(1);
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (tx_if.data_valid) begin
          // Everything the frame needs is captured here, so later changes
          // on the inputs cannot disturb the frame in flight.
          data_d    = tx_if.TX_DATA;
          par_en_d  = tx_if.parity_enable;
          par_bit_d = gen_parity;
          state_d   = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe (start bit and busy visible the cycle after accept).
  always_comb begin
    tx_out_d  = LINE_IDLE;
    busy_d    = (state_d != IDLE);
    tx_done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = data_d[bit_idx_d];
      PARITY:  tx_out_d = par_bit_d;
      default: tx_out_d = LINE_IDLE;
    endcase
  end

  // State and output registers; reset returns the line to idle-high and
  // abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_out_q  <= LINE_IDLE;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx_if.TX_OUT  = tx_out_q;
  assign tx_if.busy    = busy_q;
  assign tx_if.tx_done = tx_done_q;

endmodule
